// File: rtl/flip_arbiter.sv
// rtl/flip_arbiter.sv - round-robin arbiter feeding a registered bitwise-inverter lane
//
// Purpose:
//   N requesters share one inverter lane. Each cycle the lane can take a new
//   item, the arbiter picks one requester in round-robin order. The chosen
//   requester's data is inverted and registered, and the result is held until
//   the downstream side accepts it. The lane can complete one result and accept
//   the next in the same cycle, so it sustains one transfer per cycle.
//
// Parameters:
//   N    number of requesters (must equal 2**IDW)
//   IDW  requester-index width
//   W    data width per requester
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   req_valid   [N]     per-requester request
//   req_data    [N*W]   requester i data in bits [i*W +: W]
//   req_ready   [N]     one-hot accept strobe (combinational, zero during reset)
//   out_valid   [1]     registered result valid
//   out_data    [W]     registered bitwise inverse of the accepted data
//   out_id      [IDW]   index of the requester whose data is in out_data
//   out_ready   [1]     downstream accept (ignored while idle)
//   xfer_count  [16]    completed output transfers, wraps 16'hFFFF -> 0

module flip_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [IDW-1:0] out_id,
  input  logic           out_ready,
  output logic [15:0]    xfer_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] scan_idx;
  logic           any_req;
  logic           accept_win;
  logic           accept;
  logic           complete;

  // Round-robin scan starting at rr_ptr. The loop runs from the farthest
  // offset down to offset 0 so that the last match written is the one
  // closest to rr_ptr. Index arithmetic wraps naturally because N == 2**IDW.
  always_comb begin
    winner   = rr_ptr;
    scan_idx = rr_ptr;
    any_req  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = rr_ptr + IDW'(k);
      if (req_valid[scan_idx]) begin
        winner  = scan_idx;
        any_req = 1'b1;
      end
    end
  end

  // The lane can take a new item when it is empty, or when the held result
  // leaves in this same cycle. Reset masks acceptance so req_ready stays low.
  always_comb begin
    accept_win = (state == IDLE) || out_ready;
    accept     = accept_win && any_req && !rst;
    complete   = (state == HOLD) && out_ready;
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = {{(N-1){1'b0}}, 1'b1} << winner;
    end
  end

  // Next-state logic. In HOLD, a completion with a simultaneous acceptance
  // keeps the lane full; a completion with nothing to accept empties it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (complete && !accept) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Result register and round-robin pointer move only on acceptance, so a
  // stalled HOLD keeps both the result and the arbitration order frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_id   <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      out_data <= ~req_data[winner*W +: W];
      out_id   <= winner;
      rr_ptr   <= winner + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= 16'd0;
    end else if (complete) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end

  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_flip_arbiter.sv
// tb/tb_flip_arbiter.sv - scoreboard bench for flip_arbiter

module tb_flip_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int W   = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           out_ready;
  logic [15:0]    xfer_count;

  flip_arbiter #(.N(N), .IDW(IDW), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic           m_hold;
  logic [IDW-1:0] m_rr;
  logic [15:0]    m_count;
  logic [IDW+W-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_hold  = 1'b0;
    m_rr    = '0;
    m_count = 16'd0;
    sb.delete();
  endtask

  // Sample at the falling edge, check everything against the model,
  // advance the model, then step past the rising edge.
  task automatic cycle();
    logic           any;
    logic [IDW-1:0] w;
    logic [IDW-1:0] idx;
    logic [N-1:0]   exp_rdy;
    logic           window;
    logic [IDW+W-1:0] e;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    chk("xfer_count", 32'(xfer_count), 32'(m_count));
    if (m_hold && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("out_id", 32'(out_id), 32'(e[IDW+W-1:W]));
        chk("out_data", 32'(out_data), 32'(e[W-1:0]));
      end
      m_count = m_count + 16'd1;
    end
    window = !m_hold || out_ready;
    any = 1'b0;
    w = '0;
    for (int k = 0; k < N; k++) begin
      idx = m_rr + IDW'(k);
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        w = idx;
      end
    end
    exp_rdy = (window && any) ? (N'(1) << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (window && any) begin
      sb.push_back({w, ~req_data[w*W +: W]});
      m_rr = w + 1'b1;
      m_hold = 1'b1;
    end else if (m_hold && out_ready) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [W-1:0] held_data;
  logic [IDW-1:0] held_id;
  int iter;

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    model_reset();
    #2;

    // Reset with requests present: req_ready must stay low.
    req_valid = 4'b1111;
    do_reset();
    req_valid = '0;

    // Single request from requester 0, data 00 -> FF.
    req_valid = 4'b0001;
    req_data  = 32'h0000_0000;
    out_ready = 1'b1;
    cycle();
    req_valid = '0;
    chk("single_out_data", 32'(out_data), 32'hFF);
    chk("single_out_id", 32'(out_id), 32'd0);
    cycle();
    chk("single_count", 32'(xfer_count), 32'd1);
    cycle();

    // All requesters, continuous downstream ready: rotation 0,1,2,3,0.
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'hA5_3C_0F_81;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    req_valid = '0;
    cycle();
    cycle();

    // Backpressure: result and order frozen for 5 stalled cycles.
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h11_22_33_44;
    out_ready = 1'b0;
    cycle();
    held_data = out_data;
    held_id   = out_id;
    chk("stall_first_data", 32'(held_data), 32'hBB);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_data", 32'(out_data), 32'hBB);
      chk("stall_id", 32'(out_id), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("release_id", 32'(out_id), 32'd1);
    req_valid = '0;
    cycle();
    cycle();

    // Pointer wrap: rr=3, only requester 1 -> winner 1, then 0110 -> 2.
    do_reset();
    out_ready = 1'b1;
    req_data  = 32'h40_30_20_10;
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b0010;
    cycle();
    chk("wrap_id1", 32'(out_id), 32'd1);
    req_valid = 4'b0110;
    cycle();
    chk("wrap_id2", 32'(out_id), 32'd2);
    req_valid = '0;
    cycle();
    cycle();

    // Reset in the middle of a stalled HOLD.
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_00C3;
    out_ready = 1'b0;
    cycle();
    req_valid = '0;
    cycle();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(xfer_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b1000;
    req_data  = 32'h5A_00_00_00;
    out_ready = 1'b1;
    cycle();
    req_valid = '0;
    chk("postrst_id", 32'(out_id), 32'd3);
    chk("postrst_data", 32'(out_data), 32'hA5);
    cycle();
    cycle();

    // Random traffic, including out_ready toggling while idle.
    for (int i = 0; i < 300; i++) begin
      req_valid = N'($urandom_range(0, 15));
      req_data  = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    out_ready = 1'b1;
    req_valid = '0;
    cycle();
    cycle();

    // Counter wrap: saturate traffic until xfer_count reaches FFFF.
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'hDE_AD_BE_EF;
    out_ready = 1'b1;
    iter = 0;
    while (m_count != 16'hFFFF && iter < 70000) begin
      cycle();
      iter++;
    end
    chk("preload_bound", 32'(m_count), 32'hFFFF);
    chk("preload_count", 32'(xfer_count), 32'hFFFF);
    cycle();
    chk("wrap_count", 32'(xfer_count), 32'h0000);
    req_valid = '0;
    cycle();
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
